// File: rtl/dmem_responder.sv
// Data-memory responder for the M-stage port: word RAM plus an MMIO window holding
// a byte-wide TX FIFO, a status register and a free-running cycle counter.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      ram [DEPTH_WORDS];
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [31:0]      cycle_count;

    logic             is_mmio;
    logic [1:0]       reg_sel;
    logic [IDX_W-1:0] ram_idx;
    logic             wr_ram;
    logic             wr_tx;
    logic             wr_status;
    logic             wr_cycle;
    logic             full;
    logic             pop;
    logic             push;
    logic             ovf_set;
    logic [3:0]       count4;
    logic             unused_addr;

    // Address decode; the byte offset and the upper MMIO offset bits are don't-cares.
    assign is_mmio     = (ALUResultM[31:12] == MMIO_BASE[31:12]);
    assign reg_sel     = ALUResultM[3:2];
    assign ram_idx     = ALUResultM[IDX_W+1:2];
    assign unused_addr = ^ALUResultM;

    assign wr_ram    = MemWriteM && !is_mmio;
    assign wr_tx     = MemWriteM && is_mmio && (reg_sel == 2'd0);
    assign wr_status = MemWriteM && is_mmio && (reg_sel == 2'd1);
    assign wr_cycle  = MemWriteM && is_mmio && (reg_sel == 2'd2);

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign tx_valid = (count != '0);
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop      = tx_valid && tx_ready;
    // A pop at the same edge frees the slot, so a push into a full FIFO is still taken.
    assign push     = wr_tx && (!full || pop);
    assign ovf_set  = wr_tx && full && !pop;
    assign count4   = 4'(count);

    always_ff @(posedge clk) begin
        if (wr_ram) ram[ram_idx] <= WriteDataM;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= WriteDataM[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (wr_status && WriteDataM[2]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'd0;
        end else if (wr_cycle) begin
            cycle_count <= WriteDataM;
        end else begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Loads are combinational; a same-edge store is not visible until the next cycle.
    always_comb begin
        ReadDataM = ram[ram_idx];
        if (is_mmio) begin
            unique case (reg_sel)
                2'd1:    ReadDataM = {20'b0, count4, 5'b0, overflow, full, !tx_valid};
                2'd2:    ReadDataM = cycle_count;
                default: ReadDataM = 32'd0;
            endcase
        end
    end

endmodule
